// File: rtl/spm_ctrl_pkg.sv
// Shared definitions for the SPM scan offset control path.
package spm_ctrl_pkg;
    localparam int SPM_WIDTH = 32;
    localparam int DIV_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        MOVE,
        DONE
    } mover_state_t;
endpackage

// File: rtl/spm_offset_axis_step.sv
// One axis of the offset mover: computes the next slew-limited value toward target.
module spm_offset_axis_step
    import spm_ctrl_pkg::*;
#(
    parameter int WIDTH = SPM_WIDTH
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] target,
    input  logic [WIDTH-1:0] step,
    output logic [WIDTH-1:0] next,
    output logic             reached
);

    logic signed [WIDTH:0] diff;
    logic        [WIDTH:0] mag;

    // One extra bit keeps target - cur and its magnitude exact over the full signed range.
    always_comb begin
        diff = $signed({target[WIDTH-1], target}) - $signed({cur[WIDTH-1], cur});
        mag  = diff[WIDTH] ? $unsigned(-diff) : $unsigned(diff);
        if ((step == '0) || (mag <= {1'b0, step})) begin
            next = target;
        end else if (diff[WIDTH]) begin
            next = cur - step;
        end else begin
            next = cur + step;
        end
        reached = (next == target);
    end

endmodule

// File: rtl/axis_spm_offset_mover.sv
// Slew-rate-limited x0/y0/z0 offset generator: ramps toward latched targets on divided ticks.
module axis_spm_offset_mover
    import spm_ctrl_pkg::*;
#(
    parameter int WIDTH     = spm_ctrl_pkg::SPM_WIDTH,
    parameter int DIV_WIDTH = spm_ctrl_pkg::DIV_WIDTH
) (
    input  logic                 a_clk,
    input  logic                 a_rst,
    input  logic [WIDTH-1:0]     target_x,
    input  logic [WIDTH-1:0]     target_y,
    input  logic [WIDTH-1:0]     target_z,
    input  logic [WIDTH-1:0]     step,
    input  logic [DIV_WIDTH-1:0] tick_div,
    input  logic                 go,
    input  logic                 abort,
    output logic [WIDTH-1:0]     x0,
    output logic [WIDTH-1:0]     y0,
    output logic [WIDTH-1:0]     z0,
    output logic                 busy,
    output logic                 done,
    output logic                 at_target
);

    mover_state_t         state, state_next;
    logic                 go_d;
    logic                 go_edge;
    logic                 tick;
    logic [DIV_WIDTH-1:0] tick_cnt;
    logic [WIDTH-1:0]     lat_x, lat_y, lat_z, lat_step;
    logic [WIDTH-1:0]     nx, ny, nz;
    logic                 rx, ry, rz;
    logic                 all_reached;

    spm_offset_axis_step #(.WIDTH(WIDTH)) u_step_x (
        .cur(x0), .target(lat_x), .step(lat_step), .next(nx), .reached(rx)
    );
    spm_offset_axis_step #(.WIDTH(WIDTH)) u_step_y (
        .cur(y0), .target(lat_y), .step(lat_step), .next(ny), .reached(ry)
    );
    spm_offset_axis_step #(.WIDTH(WIDTH)) u_step_z (
        .cur(z0), .target(lat_z), .step(lat_step), .next(nz), .reached(rz)
    );

    assign go_edge     = go & ~go_d;
    assign tick        = (state == MOVE) && (tick_cnt == '0);
    assign all_reached = rx & ry & rz;

    always_ff @(posedge a_clk) begin
        if (a_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: if (go_edge) state_next = MOVE;
                MOVE: begin
                    if (go_edge) begin
                        state_next = MOVE;
                    end else if (tick && all_reached) begin
                        state_next = DONE;
                    end
                end
                DONE:    state_next = go_edge ? MOVE : IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Abort freezes position and collapses targets onto it; a go edge in any state
    // re-latches without touching the current position.
    always_ff @(posedge a_clk) begin
        if (a_rst) begin
            go_d     <= 1'b0;
            tick_cnt <= '0;
            lat_x    <= '0;
            lat_y    <= '0;
            lat_z    <= '0;
            lat_step <= '0;
            x0       <= '0;
            y0       <= '0;
            z0       <= '0;
        end else begin
            go_d <= go;
            if (abort) begin
                lat_x <= x0;
                lat_y <= y0;
                lat_z <= z0;
            end else if (go_edge) begin
                lat_x    <= target_x;
                lat_y    <= target_y;
                lat_z    <= target_z;
                lat_step <= step;
                tick_cnt <= tick_div;
            end else if (state == MOVE) begin
                if (tick) begin
                    x0       <= nx;
                    y0       <= ny;
                    z0       <= nz;
                    tick_cnt <= tick_div;
                end else begin
                    tick_cnt <= tick_cnt - DIV_WIDTH'(1);
                end
            end
        end
    end

    assign busy      = (state == MOVE);
    assign done      = (state == DONE);
    assign at_target = (x0 == lat_x) && (y0 == lat_y) && (z0 == lat_z);

endmodule

// File: doc/axis_spm_offset_mover.md
Name: axis_spm_offset_mover

Overview:
- Slew-rate-limited generator for the absolute scan offset vector x0/y0/z0 that feeds the SPM control stage directly.
- Software writes target offsets and a step size, then strobes go. The block ramps all three components toward their targets at a programmable rate, which prevents piezo jumps.
- Reports busy and done status back to the PS register bank.

Parameters:
- WIDTH, 32: offset and target component width (signed two's complement).
- DIV_WIDTH, 16: width of the tick divider.

Ports:
- a_clk  in  1  system clock.
- a_rst  in  1  synchronous, active-high reset.
- target_x  in  WIDTH  X offset target (signed).
- target_y  in  WIDTH  Y offset target (signed).
- target_z  in  WIDTH  Z offset target (signed).
- step  in  WIDTH  maximum per-tick change, unsigned; 0 means jump.
- tick_div  in  DIV_WIDTH  one update tick every tick_div+1 clocks.
- go  in  1  level control bit; the rising edge starts a move.
- abort  in  1  level; while high, freeze and force IDLE.
- x0  out  WIDTH  current X offset, to the control stage.
- y0  out  WIDTH  current Y offset.
- z0  out  WIDTH  current Z offset.
- busy  out  1  high in state MOVE.
- done  out  1  one-cycle pulse when the move completes.
- at_target  out  1  high when all three current values equal the latched targets.

Behaviour:
- Clock and reset: single clock a_clk; reset a_rst is synchronous and active-high.
- Reset values: x0=y0=z0=0; latched targets=0; latched step=0; tick counter=0; go_d=0; state IDLE; busy=0; done=0; at_target=1.
- go edge detection: go_d registers go. A go edge is go=1 with go_d=0, evaluated at a clock edge.
- FSM states: IDLE, MOVE, DONE.
- IDLE -> MOVE on a go edge:
  - target_x/y/z and step are snapshot-latched at the same edge.
  - The tick counter is loaded with tick_div.
  - busy=1 from the next cycle.
  - Later changes to the input registers are ignored until the next go edge.
- MOVE, tick counter:
  - The counter decrements each clock. When it reaches 0, a tick occurs and the counter reloads tick_div.
  - The first tick occurs tick_div+1 clocks after the go edge.
- MOVE, per-component update on each tick:
  - diff = target - cur, computed in WIDTH+1 bits signed.
  - If latched step==0, or |diff| <= step (compared in WIDTH+1 bits), then cur <= target.
  - Otherwise cur <= cur + step when diff>0, or cur - step when diff<0.
  - Overflow is impossible because cur always moves toward a representable target. No saturation logic is needed.
  - All three components update on the same tick and finish independently.
- MOVE -> DONE on the first tick after which all three components equal their targets. The comparison uses the post-update values, evaluated combinationally from next-state.
- DONE: done=1 for exactly one cycle, busy=0, then the FSM returns to IDLE.
- go edge during MOVE (retarget):
  - Targets and step are re-latched and the tick counter reloads.
  - The FSM stays in MOVE, and the current position is kept (no jump).
- go edge during DONE: treated as an IDLE go edge (enter MOVE), and done is still pulsed.
- abort=1:
  - Forces IDLE the next cycle and holds x0/y0/z0 at their current values.
  - Latched targets are set to the current values, so at_target=1.
  - No done pulse is generated.
  - abort has priority over a simultaneous go edge.
- go edge while at target: MOVE is entered, and DONE follows on the first tick.
- Reset asserted mid-move: outputs return to 0 at the next edge. A hard jump is accepted, since reset is a system-level event.
- Latency: x0/y0/z0 are registered outputs and change only on tick edges.

Decomposition:
- Shared package spm_ctrl_pkg:
  - Constants SPM_WIDTH=32 and DIV_WIDTH=16.
  - FSM state enum mover_state_t {IDLE, MOVE, DONE}.
- Sub-module spm_offset_axis_step, instantiated 3 times:
  - Purely combinational: cur, target, step -> next, reached.
  - Holds the WIDTH+1 diff/compare logic.
- The top level holds the go edge detect, tick counter, FSM, and output registers.

Test Plan:
- Basic ramp: reset; target_x=250, step=100, tick_div=0, go pulse -> x0 = 100, 200, 250 on consecutive clocks; done pulses once; busy low after; y0=z0=0.
- Negative move: from x0=250, target_x=-50, step=100, tick_div=3 -> x0 = 150, 50, -50, with each change 4 clocks apart; done pulses 1 cycle.
- Jump and extremes: step=0, target_z=0x7FFFFFFF -> z0 jumps at the first tick, done follows. Then step=0x80000000, target_z=0x80000000 -> z0 reaches -2^31 after 2 ticks with no wrap.
- Abort: target_y=1000, step=10, tick_div=0, abort after 5 ticks -> y0 frozen at 50, busy=0, at_target=1, no done pulse; abort held with a go edge -> stays IDLE.
- Retarget: during a move to x=1000 step=100, at x0=300 a new go edge with target_x=0 -> x0 = 200, 100, 0, one done pulse total. Changing target_x without a go edge -> ignored.
- Reset mid-move: assert a_rst at x0=500 -> next edge x0=0, busy=0, at_target=1, done=0.
